// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: segment bit positions,
// legal lit patterns (gfedcba) and the sampling FSM state type.
package seg_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] PAT_0     = 7'h3F;
  localparam logic [6:0] PAT_1     = 7'h06;
  localparam logic [6:0] PAT_2     = 7'h5B;
  localparam logic [6:0] PAT_3     = 7'h4F;
  localparam logic [6:0] PAT_4     = 7'h66;
  localparam logic [6:0] PAT_5     = 7'h6D;
  localparam logic [6:0] PAT_6     = 7'h7D;
  localparam logic [6:0] PAT_6_ALT = 7'h7C;
  localparam logic [6:0] PAT_7     = 7'h07;
  localparam logic [6:0] PAT_7_ALT = 7'h27;
  localparam logic [6:0] PAT_8     = 7'h7F;
  localparam logic [6:0] PAT_9     = 7'h6F;
  localparam logic [6:0] PAT_9_ALT = 7'h67;
  localparam logic [6:0] PAT_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] BAD_CODE   = 4'hF;

  typedef enum logic {
    StSettle,
    StHold
  } state_e;

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational lit-segment pattern to BCD decode; illegal patterns yield BAD_CODE,
// an unlit digit yields BLANK_CODE.
module seg7_pattern_decoder
  import seg_pkg::*;
(
  input  logic [6:0] lit,
  output logic [3:0] digit,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    digit = BAD_CODE;
    legal = 1'b1;
    blank = 1'b0;
    case (lit)
      PAT_0:                digit = 4'd0;
      PAT_1:                digit = 4'd1;
      PAT_2:                digit = 4'd2;
      PAT_3:                digit = 4'd3;
      PAT_4:                digit = 4'd4;
      PAT_5:                digit = 4'd5;
      PAT_6, PAT_6_ALT:     digit = 4'd6;
      PAT_7, PAT_7_ALT:     digit = 4'd7;
      PAT_8:                digit = 4'd8;
      PAT_9, PAT_9_ALT:     digit = 4'd9;
      PAT_BLANK: begin
        digit = BLANK_CODE;
        legal = 1'b0;
        blank = 1'b1;
      end
      default:              legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_scan_decoder.sv
// Monitors multiplexed seven-segment pins, samples each settled anode/cathode pair
// once, and rebuilds the displayed digits with frame and error reporting.
module segment_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern,
  output logic                    err_an,
  output logic [2:0]              err_digit
);

  localparam int unsigned InW    = NUM_DIGITS + 7;
  localparam logic [7:0]  CntMax = 8'(STABLE_CYCLES - 1);

  logic [InW-1:0]          in_q;
  logic [7:0]              cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic                    changed, sample;

  logic [6:0]              lit;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [3:0]              dec_digit;
  logic                    dec_legal, dec_blank;

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;
  logic                    err_pat_q, err_pat_d;
  logic                    err_an_q, err_an_d;
  logic [2:0]              err_digit_q, err_digit_d;

  assign changed = ({an_n, seg_n} != in_q);
  assign lit     = ~in_q[SEG_G:SEG_A];
  assign an_act  = ~in_q[InW-1:7];

  seg7_pattern_decoder u_dec (
    .lit   (lit),
    .digit (dec_digit),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // A change arriving on the sampling edge drops straight back to settling.
  always_comb begin
    state_d = state_q;
    sample  = 1'b0;
    case (state_q)
      StSettle: begin
        if (cnt_q == CntMax) begin
          sample  = 1'b1;
          state_d = changed ? StSettle : StHold;
        end
      end
      StHold: begin
        if (changed) state_d = StSettle;
      end
      default: state_d = StSettle;
    endcase
  end

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_pat_d    = 1'b0;
    err_an_d     = 1'b0;
    err_digit_d  = err_digit_q;
    frame_done_d = &seen_q;
    // Clear first so a coincident sample counts toward the next frame.
    seen_d       = frame_done_d ? '0 : seen_q;
    if (sample && (an_act != '0)) begin
      if ($onehot(an_act)) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (an_act[k]) begin
            seen_d[k]         = 1'b1;
            digits_d[4*k +: 4] = dec_digit;
            valid_d[k]        = dec_legal;
            if (!dec_legal && !dec_blank) begin
              err_pat_d   = 1'b1;
              err_digit_d = 3'(k);
            end
          end
        end
      end else begin
        err_an_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q         <= '1;
      cnt_q        <= 8'd0;
      state_q      <= StSettle;
      digits_q     <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      err_pat_q    <= 1'b0;
      err_an_q     <= 1'b0;
      err_digit_q  <= 3'd0;
    end else begin
      in_q         <= {an_n, seg_n};
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      err_pat_q    <= err_pat_d;
      err_an_q     <= err_an_d;
      err_digit_q  <= err_digit_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign err_pattern = err_pat_q;
  assign err_an      = err_an_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: vector table plus hand-written
// glitch, timing and reset sequences.
module tb_segment_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err_pattern;
  logic        err_an;
  logic [2:0]  err_digit;

  segment_scan_decoder #(
    .NUM_DIGITS    (8),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_an      (err_an),
    .err_digit   (err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int ae_cnt = 0;

  // Counts high cycles, so a pulse wider than one cycle shows up as extra counts.
  always @(negedge clk) begin
    if (frame_done)  fd_cnt++;
    if (err_pattern) pe_cnt++;
    if (err_an)      ae_cnt++;
  end

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  lit;
    int          hold;
    logic [31:0] exp_digits;
    logic [7:0]  exp_valid;
    int          exp_pe;
    int          exp_ae;
    logic [2:0]  exp_errd;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Called 1ns after a rising edge; pins are then seen by exactly n rising edges.
  task automatic apply(input logic [7:0] an, input logic [6:0] lit, input int n);
    an_n  = an;
    seg_n = ~lit;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int pe0, ae0;
    pe0 = pe_cnt;
    ae0 = ae_cnt;
    apply(vecs[i].an, vecs[i].lit, vecs[i].hold);
    chk($sformatf("v%0d digits", i), digits, vecs[i].exp_digits);
    chk($sformatf("v%0d valid", i), 32'(digit_valid), 32'(vecs[i].exp_valid));
    chk($sformatf("v%0d err_pattern pulses", i), 32'(pe_cnt - pe0), 32'(vecs[i].exp_pe));
    chk($sformatf("v%0d err_an pulses", i), 32'(ae_cnt - ae0), 32'(vecs[i].exp_ae));
    chk($sformatf("v%0d err_digit", i), 32'(err_digit), 32'(vecs[i].exp_errd));
  endtask

  initial begin
    int fd0, pe0, ae0;

    // Scan 3,1,4,1,5,9,2,6 then blanking and a too-short glitch.
    vecs[0]  = '{8'hFE, 7'h4F, 10, 32'h0000_0003, 8'h01, 0, 0, 3'd0};
    vecs[1]  = '{8'hFD, 7'h06, 10, 32'h0000_0013, 8'h03, 0, 0, 3'd0};
    vecs[2]  = '{8'hFB, 7'h66, 10, 32'h0000_0413, 8'h07, 0, 0, 3'd0};
    vecs[3]  = '{8'hF7, 7'h06, 10, 32'h0000_1413, 8'h0F, 0, 0, 3'd0};
    vecs[4]  = '{8'hEF, 7'h6D, 10, 32'h0005_1413, 8'h1F, 0, 0, 3'd0};
    vecs[5]  = '{8'hDF, 7'h6F, 10, 32'h0095_1413, 8'h3F, 0, 0, 3'd0};
    vecs[6]  = '{8'hBF, 7'h5B, 10, 32'h0295_1413, 8'h7F, 0, 0, 3'd0};
    vecs[7]  = '{8'h7F, 7'h7D, 10, 32'h6295_1413, 8'hFF, 0, 0, 3'd0};
    vecs[8]  = '{8'hFF, 7'h00, 10, 32'h6295_1413, 8'hFF, 0, 0, 3'd0};
    vecs[9]  = '{8'hFB, 7'h7F,  3, 32'h6295_1413, 8'hFF, 0, 0, 3'd0};
    vecs[10] = '{8'hFF, 7'h00,  6, 32'h6295_1413, 8'hFF, 0, 0, 3'd0};
    // Bad pattern, anode fault, blanking, alternates and blank digit.
    vecs[11] = '{8'hFB, 7'h49,  6, 32'h6295_1F13, 8'hFB, 1, 0, 3'd2};
    vecs[12] = '{8'hFC, 7'h3F,  6, 32'h6295_1F13, 8'hFB, 0, 1, 3'd2};
    vecs[13] = '{8'hFF, 7'h3F,  6, 32'h6295_1F13, 8'hFB, 0, 0, 3'd2};
    vecs[14] = '{8'hFE, 7'h7C, 10, 32'h6295_1F16, 8'hFB, 0, 0, 3'd2};
    vecs[15] = '{8'hFD, 7'h00, 10, 32'h6295_1FA6, 8'hF9, 0, 0, 3'd2};
    vecs[16] = '{8'hFE, 7'h27, 10, 32'h6295_1FA7, 8'hF9, 0, 0, 3'd2};
    vecs[17] = '{8'hFE, 7'h67, 10, 32'h6295_1FA9, 8'hF9, 0, 0, 3'd2};

    rst_n = 1'b0;
    an_n  = 8'hFF;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("reset digits", digits, 32'h0);
    chk("reset valid", 32'(digit_valid), 32'h0);
    chk("reset pulses", {29'd0, frame_done, err_pattern, err_an}, 32'h0);
    chk("reset err_digit", 32'(err_digit), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i <= 7; i++) run_vec(i);
    chk("frame_done after first scan", 32'(fd_cnt), 32'd1);
    for (int i = 8; i <= 10; i++) run_vec(i);

    // Four-cycle hold: nibble 2 updates on the fourth edge after capture, not before.
    pe0 = pe_cnt;
    ae0 = ae_cnt;
    apply(8'hFB, 7'h7F, 4);
    chk("glitch accept before window", 32'(digits[11:8]), 32'h4);
    @(posedge clk);
    #1;
    chk("glitch accept at window", digits, 32'h6295_1813);
    repeat (6) @(posedge clk);
    #1;
    chk("glitch hold stable", digits, 32'h6295_1813);
    chk("glitch no errors", 32'((pe_cnt - pe0) + (ae_cnt - ae0)), 32'd0);

    for (int i = 11; i <= 17; i++) run_vec(i);
    chk("no extra frame_done", 32'(fd_cnt), 32'd1);

    // Partial frame, then asynchronous reset between clock edges.
    for (int i = 0; i <= 3; i++) apply(vecs[i].an, vecs[i].lit, 10);
    an_n  = 8'hFF;
    seg_n = 7'h7F;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset digits", digits, 32'h0);
    chk("async reset valid", 32'(digit_valid), 32'h0);
    chk("async reset pulses", {29'd0, frame_done, err_pattern, err_an}, 32'h0);
    chk("async reset err_digit", 32'(err_digit), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fd0 = fd_cnt;
    for (int i = 0; i <= 7; i++) run_vec(i);
    repeat (4) @(posedge clk);
    #1;
    chk("frame_done after reset scan", 32'(fd_cnt - fd0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
